// File: rtl/alu_result_stage_pkg.sv
// Shared opcodes, FSM state encoding and the per-entry tag carried next to
// each result through the alu_result_stage skid buffer.
package alu_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_INC  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Width-independent part of a result entry; the data field is added by the
  // stage itself because its width follows the stage parameter.
  typedef struct packed {
    logic [2:0] op;
    logic       z;
    logic       n;
    logic       c;
  } entry_tag_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (function-unit results) and downstream (registered result) handshake
// bundle of alu_result_stage. master = traffic source/sink, slave = the stage.
interface alu_result_stage_if #(
  parameter int size = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [8*size-1:0] res_bus;
  logic [7:0]        carry_bus;
  logic              out_valid;
  logic              out_ready;
  logic [size-1:0]   out_data;
  logic [2:0]        out_op;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;

  modport master (
    output in_valid, in_op, res_bus, carry_bus, out_ready,
    input  in_ready, out_valid, out_data, out_op, flag_z, flag_n, flag_c
  );

  modport slave (
    input  in_valid, in_op, res_bus, carry_bus, out_ready,
    output in_ready, out_valid, out_data, out_op, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational status-flag generator used on the capture path of
// alu_result_stage: zero, negative (MSB) and the unit's own carry.
module alu_flag_gen #(
  parameter int size = 4
) (
  input  logic [size-1:0] data,
  input  logic            carry,
  output logic            z,
  output logic            n,
  output logic            c
);
  assign z = (data == '0);
  assign n = data[size-1];
  assign c = carry;
endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: opcode select, flag capture, 2-entry skid buffer.
// Optional ALU_RESULT_STATS_EN adds res_count / zero_count handshake counters.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int size = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [7:0]          res_count,
  output logic [7:0]          zero_count
`endif
);

  typedef struct packed {
    logic [size-1:0] data;
    entry_tag_t      tag;
  } entry_t;

  state_t          state, state_next;
  entry_t          main_q, skid_q, cap;
  logic            in_ready_q;
  logic            accept, pop;
  logic            load_main, load_skid, skid_to_main;
  logic [size-1:0] sel_data;
  logic            sel_carry, cap_z, cap_n, cap_c;

  assign sel_data  = bus.res_bus[bus.in_op*size +: size];
  assign sel_carry = bus.carry_bus[bus.in_op];

  alu_flag_gen #(.size(size)) u_flag_gen (
    .data  (sel_data),
    .carry (sel_carry),
    .z     (cap_z),
    .n     (cap_n),
    .c     (cap_c)
  );

  assign cap    = '{data: sel_data, tag: '{op: bus.in_op, z: cap_z, n: cap_n, c: cap_c}};
  assign accept = bus.in_valid && in_ready_q;
  assign pop    = (state != ST_EMPTY) && bus.out_ready;

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: if (accept) begin
        state_next = ST_ONE;
        load_main  = 1'b1;
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        state_next   = ST_ONE;
        skid_to_main = 1'b1;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_FULL);
      if (load_main)         main_q <= cap;
      else if (skid_to_main) main_q <= skid_q;
    end
  end

  // NOTE: the skid entry has no reset; it is only ever read after being loaded,
  // and reset empties the FSM so a stale value can never reach the outputs.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= cap;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_data  = main_q.data;
  assign bus.out_op    = main_q.tag.op;
  assign bus.flag_z    = main_q.tag.z;
  assign bus.flag_n    = main_q.tag.n;
  assign bus.flag_c    = main_q.tag.c;

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_count  <= 8'd0;
      zero_count <= 8'd0;
    end else if (pop) begin
      res_count <= res_count + 8'd1;
      if (main_q.tag.z && zero_count != 8'hFF) zero_count <= zero_count + 8'd1;
    end
  end
`endif

endmodule
